// File: rtl/alu_result_buffer.sv
// alu_result_buffer
//   Sits behind the registered ALU adder. When an op is issued, the adder
//   result and flags become valid one cycle later. This block captures them
//   at that point and queues them in a small FIFO. Writeback drains the FIFO
//   over a valid/ready handshake. The block also keeps sticky carry, overflow
//   and dropped-op status.
//
// Ports
//   elk, rst              clock (rising edge); asynchronous active-high reset
//   issue, issue_sel      op driven into the adder this cycle, and its sel
//   in_ready              an issue this cycle is guaranteed a FIFO slot
//   alu_res/z/c/v         registered adder outputs (valid the cycle after issue)
//   out_valid, out_ready  head-of-FIFO handshake to writeback
//   wb_res/z/c/v/err      head entry fields; all zero while the FIFO is empty
//   sticky_c, sticky_v    carry/overflow seen on any captured supported op
//   drop_err              an issue arrived while in_ready was low
//   clr_sticky            synchronous clear of the three sticky bits
//
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and the
// head fields stay stable while out_valid=1 and out_ready=0.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        elk,
    input  logic        rst,
    input  logic        issue,
    input  logic [2:0]  issue_sel,
    output logic        in_ready,
    input  logic [31:0] alu_res,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_res,
    output logic        wb_z,
    output logic        wb_c,
    output logic        wb_v,
    output logic        wb_err,
    output logic        sticky_c,
    output logic        sticky_v,
    output logic        drop_err,
    input  logic        clr_sticky
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW+1:0] DEPTH_L = DEPTH[AW+1:0];

    // Entry layout: {res[31:0], z, c, v, err}
    logic [35:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pend_q, pend_d;
    logic [2:0]    pend_sel_q, pend_sel_d;
    logic          sticky_c_q, sticky_c_d;
    logic          sticky_v_q, sticky_v_d;
    logic          drop_err_q, drop_err_d;

    logic          push, pop, entry_err;
    logic          set_c, set_v, set_drop;
    logic [AW+1:0] occupancy;
    logic [35:0]   head;

    // A slot is reserved for the op still in the pending stage. Because of
    // this, a push into a full FIFO cannot happen.
    always_comb begin
        occupancy = {1'b0, count_q} + {{(AW+1){1'b0}}, pend_q};
        in_ready  = ~rst & (occupancy < DEPTH_L);
    end

    always_comb begin
        push      = pend_q;
        out_valid = (count_q != '0);
        pop       = out_valid & out_ready;
        entry_err = (pend_sel_q != 3'b000);

        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end

        pend_d     = issue & in_ready;
        pend_sel_d = issue_sel;

        // Unsupported ops carry stale adder flags, so they must not feed
        // the sticky status.
        set_c    = push & ~entry_err & alu_c;
        set_v    = push & ~entry_err & alu_v;
        set_drop = issue & ~in_ready;

        // A set in the same edge as a clear wins.
        sticky_c_d = clr_sticky ? set_c    : (sticky_c_q | set_c);
        sticky_v_d = clr_sticky ? set_v    : (sticky_v_q | set_v);
        drop_err_d = clr_sticky ? set_drop : (drop_err_q | set_drop);
    end

    always_ff @(posedge elk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            pend_sel_q <= 3'b000;
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            sticky_c_q <= sticky_c_d;
            sticky_v_q <= sticky_v_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge elk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {alu_res, alu_z, alu_c, alu_v, entry_err};
        end
    end

    always_comb begin
        head   = out_valid ? mem_q[rd_ptr_q] : 36'd0;
        wb_res = head[35:4];
        wb_z   = head[3];
        wb_c   = head[2];
        wb_v   = head[1];
        wb_err = head[0];
    end

    assign sticky_c = sticky_c_q;
    assign sticky_v = sticky_v_q;
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  // ---------------- clock / reset ----------------
  logic        elk = 1'b0;
  logic        rst = 1'b1;
  always #5 elk = ~elk;

  logic        issue = 1'b0;
  logic [2:0]  issue_sel = 3'b000;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;

  logic [31:0] alu_res = 32'd0;
  logic        alu_z = 1'b0;
  logic        alu_c = 1'b0;
  logic        alu_v = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] wb_res;
  logic        wb_z, wb_c, wb_v, wb_err;
  logic        sticky_c, sticky_v, drop_err;

  alu_result_buffer #(.DEPTH(4), .AW(2)) dut (
    .elk(elk), .rst(rst), .issue(issue), .issue_sel(issue_sel),
    .in_ready(in_ready), .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c),
    .alu_v(alu_v), .out_valid(out_valid), .out_ready(out_ready),
    .wb_res(wb_res), .wb_z(wb_z), .wb_c(wb_c), .wb_v(wb_v), .wb_err(wb_err),
    .sticky_c(sticky_c), .sticky_v(sticky_v), .drop_err(drop_err),
    .clr_sticky(clr_sticky)
  );

  // Registered adder upstream; unsupported sels leave its outputs unchanged.
  logic [32:0] sum_t;
  always @(posedge elk) begin
    if (issue && issue_sel == 3'b000) begin
      sum_t = {1'b0, op_a} + {1'b0, op_b};
      alu_res <= sum_t[31:0];
      alu_c   <= sum_t[32];
      alu_z   <= (sum_t[31:0] == 32'd0);
      alu_v   <= (op_a[31] == op_b[31]) && (sum_t[31] != op_a[31]);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted ops live in a queue. An op is visible one edge after issue,
  // and a slot is held for an op that is still in flight.
  logic [35:0] exp_q[$];
  bit          m_pend = 1'b0;
  bit          m_pend_err = 1'b0;
  bit          m_sc = 1'b0, m_sv = 1'b0, m_drop = 1'b0;

  always @(posedge elk or posedge rst) begin
    bit room, sc, sv, sd;
    if (rst) begin
      exp_q.delete();
      m_pend = 1'b0; m_pend_err = 1'b0;
      m_sc = 1'b0; m_sv = 1'b0; m_drop = 1'b0;
    end else begin
      room = (exp_q.size() + int'(m_pend)) < 4;
      sc = 1'b0; sv = 1'b0;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (m_pend) begin
        exp_q.push_back({alu_res, alu_z, alu_c, alu_v, m_pend_err});
        if (!m_pend_err) begin sc = alu_c; sv = alu_v; end
      end
      sd = issue && !room;
      m_pend     = issue && room;
      m_pend_err = (issue_sel != 3'b000);
      if (clr_sticky) begin
        m_sc = sc; m_sv = sv; m_drop = sd;
      end else begin
        m_sc |= sc; m_sv |= sv; m_drop |= sd;
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge elk) begin
    logic [35:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : 36'd0;
    chk1("out_valid", out_valid, exp_q.size() != 0);
    chk1("in_ready", in_ready, !rst && ((exp_q.size() + int'(m_pend)) < 4));
    chk32("wb_res", wb_res, h[35:4]);
    chk1("wb_z", wb_z, h[3]);
    chk1("wb_c", wb_c, h[2]);
    chk1("wb_v", wb_v, h[1]);
    chk1("wb_err", wb_err, h[0]);
    chk1("sticky_c", sticky_c, m_sc);
    chk1("sticky_v", sticky_v, m_sv);
    chk1("drop_err", drop_err, m_drop);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge elk);
    #1;
  endtask

  task automatic issue_one(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    issue = 1'b1; issue_sel = sel; op_a = a; op_b = b;
    tick();
    issue = 1'b0; issue_sel = 3'b000;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge elk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: out_valid never rose within 8 cycles", name);
    end
  endtask

  task automatic pulse_clr();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(); tick();
    @(negedge elk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_drop_err", drop_err, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // 5 + 7
    issue_one(3'b000, 32'd5, 32'd7);
    wait_valid("add_5_7");
    chk32("add_5_7_res", wb_res, 32'd12);
    chk1("add_5_7_z", wb_z, 1'b0);
    chk1("add_5_7_c", wb_c, 1'b0);
    chk1("add_5_7_v", wb_v, 1'b0);
    chk1("add_5_7_err", wb_err, 1'b0);
    tick(); tick();

    // Signed overflow, then clear the sticky
    issue_one(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_valid("ovf");
    chk32("ovf_res", wb_res, 32'h8000_0000);
    chk1("ovf_v", wb_v, 1'b1);
    chk1("ovf_c", wb_c, 1'b0);
    chk1("ovf_sticky_v", sticky_v, 1'b1);
    tick();
    pulse_clr();
    @(negedge elk);
    chk1("clr_sticky_v", sticky_v, 1'b0);

    // Carry out with zero result
    tick();
    issue_one(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_valid("carry");
    chk32("carry_res", wb_res, 32'd0);
    chk1("carry_z", wb_z, 1'b1);
    chk1("carry_c", wb_c, 1'b1);
    chk1("carry_v", wb_v, 1'b0);
    chk1("carry_sticky_c", sticky_c, 1'b1);
    tick(); tick();

    // Fill with writeback stalled; the 5th issue is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk1("full_in_ready", in_ready, 1'b0);
      issue = 1'b1; issue_sel = 3'b000;
      op_a = 32'(10 * (i + 1)); op_b = 32'(i + 1);
      tick();
    end
    issue = 1'b0;
    @(negedge elk);
    chk1("full_drop_err", drop_err, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk32("drain_res", wb_res, 32'(11 * (i + 1)));
      @(posedge elk);
      @(negedge elk);
    end
    chk1("drain_empty", out_valid, 1'b0);
    tick();

    // Back-to-back streaming with writeback always ready
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      issue = 1'b1; issue_sel = 3'b000;
      op_a = 32'(3 * i); op_b = 32'd1000;
      chk1("stream_in_ready", in_ready, 1'b1);
      tick();
      if (i >= 2) chk1("stream_valid", out_valid, 1'b1);
    end
    issue = 1'b0;
    tick(); tick(); tick();
    chk1("stream_no_drop", drop_err, 1'b0);
    chk1("stream_empty", out_valid, 1'b0);

    // Unsupported sel: stale flags are queued, but the sticky bits stay clear
    issue_one(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
    tick(); tick(); tick();
    pulse_clr();
    issue_one(3'b001, 32'd1, 32'd1);
    wait_valid("unsup");
    chk1("unsup_err", wb_err, 1'b1);
    chk1("unsup_stale_c", wb_c, 1'b1);
    chk32("unsup_stale_res", wb_res, 32'd0);
    chk1("unsup_sticky_c", sticky_c, 1'b0);
    tick(); tick();

    // Reset with two entries queued and one pending
    out_ready = 1'b0;
    issue = 1'b1; issue_sel = 3'b000; op_a = 32'd1; op_b = 32'd2;
    tick(); tick(); tick();
    issue = 1'b0;
    chk1("pre_rst_valid", out_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk32("async_rst_res", wb_res, 32'd0);
    chk1("async_rst_in_ready", in_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge elk);
      chk1("post_rst_empty", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
